// File: rtl/flag_branch_pkg.sv
// ============================================================================
// Module      : flag_branch_pkg
// Description : Shared types for the flag register / branch-condition unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package flag_branch_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    typedef enum logic [1:0] {
        EK_B     = 2'b00,
        EK_BCOND = 2'b01,
        EK_CBZ   = 2'b10,
        EK_CBNZ  = 2'b11
    } eval_kind_e;

    typedef enum logic [3:0] {
        CC_EQ = 4'b0000,
        CC_NE = 4'b0001,
        CC_HS = 4'b0010,
        CC_LO = 4'b0011,
        CC_MI = 4'b0100,
        CC_PL = 4'b0101,
        CC_VS = 4'b0110,
        CC_VC = 4'b0111,
        CC_HI = 4'b1000,
        CC_LS = 4'b1001,
        CC_GE = 4'b1010,
        CC_LT = 4'b1011,
        CC_GT = 4'b1100,
        CC_LE = 4'b1101,
        CC_AL = 4'b1110,
        CC_NV = 4'b1111
    } cond_e;

endpackage

`default_nettype wire

// File: rtl/flag_branch_unit_cond_eval.sv
// ============================================================================
// Module      : cond_eval
// Description : Combinational condition-code decode of {N,Z,V,C} into a hit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_eval
    import flag_branch_pkg::*;
(
    input  flags_t     flags,
    input  logic [3:0] cond,
    output logic       hit
);

    logic base;

    // Even codes define the base test; odd codes are its inverse, except NV.
    always_comb begin
        base = 1'b0;
        case (cond_e'({cond[3:1], 1'b0}))
            CC_EQ:   base = flags.z;
            CC_HS:   base = flags.c;
            CC_MI:   base = flags.n;
            CC_VS:   base = flags.v;
            CC_HI:   base = flags.c & ~flags.z;
            CC_GE:   base = (flags.n == flags.v);
            CC_GT:   base = ~flags.z & (flags.n == flags.v);
            CC_AL:   base = 1'b1;
            default: base = 1'b0;
        endcase
    end

    assign hit = (cond[0] && (cond[3:1] != 3'b111)) ? ~base : base;

endmodule

`default_nettype wire

// File: rtl/flag_branch_unit.sv
// ============================================================================
// Module      : flag_branch_unit
// Description : NZVC flag register plus B / B.cond / CBZ / CBNZ evaluator with
//               registered decision and saturating taken-branch counter.
//               Define FLAG_FWD_EN to forward same-cycle ALU flags to B.cond.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_branch_unit
    import flag_branch_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,
    input  logic             set_flags,
    input  logic             eval_valid,
    input  logic [1:0]       eval_kind,
    input  logic [3:0]       cond,
    input  logic             cbz_zero,
    output logic [3:0]       flags_q,
    output logic             flags_valid,
    output logic             take_valid,
    output logic             take,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    flags_t            flag_reg_q,    flag_reg_d;
    logic              flags_valid_q, flags_valid_d;
    logic              take_valid_q,  take_valid_d;
    logic              take_q,        take_d;
    logic [CNT_W-1:0]  taken_count_q, taken_count_d;

    flags_t            alu_flags;
    flags_t            eval_flags;
    logic              cond_hit;
    logic              decision;

    assign alu_flags = '{n: alu_negative, z: alu_zero, v: alu_overflow, c: alu_carry_out};

`ifdef FLAG_FWD_EN
    assign eval_flags = set_flags ? alu_flags : flag_reg_q;
`else
    assign eval_flags = flag_reg_q;
`endif

    cond_eval u_cond_eval (
        .flags (eval_flags),
        .cond  (cond),
        .hit   (cond_hit)
    );

    always_comb begin
        decision = 1'b0;
        case (eval_kind_e'(eval_kind))
            EK_B:     decision = 1'b1;
            EK_BCOND: decision = cond_hit;
            EK_CBZ:   decision = cbz_zero;
            EK_CBNZ:  decision = ~cbz_zero;
            default:  decision = 1'b0;
        endcase
    end

    always_comb begin
        flag_reg_d    = flag_reg_q;
        flags_valid_d = flags_valid_q;
        if (set_flags) begin
            flag_reg_d    = alu_flags;
            flags_valid_d = 1'b1;
        end
        take_valid_d  = eval_valid;
        take_d        = eval_valid & decision;
        taken_count_d = taken_count_q;
        if (eval_valid && decision && (taken_count_q != C_CNT_MAX)) begin
            taken_count_d = taken_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_reg_q    <= '0;
            flags_valid_q <= 1'b0;
            take_valid_q  <= 1'b0;
            take_q        <= 1'b0;
            taken_count_q <= '0;
        end else begin
            flag_reg_q    <= flag_reg_d;
            flags_valid_q <= flags_valid_d;
            take_valid_q  <= take_valid_d;
            take_q        <= take_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign flags_q     = flag_reg_q;
    assign flags_valid = flags_valid_q;
    assign take_valid  = take_valid_q;
    assign take        = take_q;
    assign taken_count = taken_count_q;

endmodule

`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
// ============================================================================
// Module      : tb_flag_branch_unit
// Description : Self-checking bench for flag_branch_unit (CNT_W=4); honours
//               FLAG_FWD_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flag_branch_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic             set_flags;
    logic             eval_valid;
    logic [1:0]       eval_kind;
    logic [3:0]       cond;
    logic             cbz_zero;
    logic [3:0]       flags_q;
    logic             flags_valid;
    logic             take_valid;
    logic             take;
    logic [CNT_W-1:0] taken_count;

    int vectors     = 0;
    int miscompares = 0;
    bit started     = 0;

    flag_branch_unit #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .alu_negative  (alu_negative),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .alu_carry_out (alu_carry_out),
        .set_flags     (set_flags),
        .eval_valid    (eval_valid),
        .eval_kind     (eval_kind),
        .cond          (cond),
        .cbz_zero      (cbz_zero),
        .flags_q       (flags_q),
        .flags_valid   (flags_valid),
        .take_valid    (take_valid),
        .take          (take),
        .taken_count   (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [3:0] m_flags = 4'h0;
    logic       m_fv    = 1'b0;
    logic       m_tv    = 1'b0;
    logic       m_t     = 1'b0;
    int         m_cnt   = 0;
    logic [3:0] m_in_flags;
    logic [3:0] m_eval_flags;

    function automatic logic decide(input logic [1:0] k, input logic [3:0] c,
                                    input logic [3:0] f, input logic cbz);
        logic n, z, v, cc;
        n = f[3]; z = f[2]; v = f[1]; cc = f[0];
        if (k == 2'b00) return 1'b1;
        if (k == 2'b10) return cbz;
        if (k == 2'b11) return !cbz;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cc;
            4'd3:    return !cc;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cc && !z;
            4'd9:    return !(cc && !z);
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    assign m_in_flags = {alu_negative, alu_zero, alu_overflow, alu_carry_out};
`ifdef FLAG_FWD_EN
    assign m_eval_flags = set_flags ? m_in_flags : m_flags;
`else
    assign m_eval_flags = m_flags;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_flags <= 4'h0;
            m_fv    <= 1'b0;
            m_tv    <= 1'b0;
            m_t     <= 1'b0;
            m_cnt   <= 0;
        end else begin
            m_tv <= eval_valid;
            m_t  <= eval_valid && decide(eval_kind, cond, m_eval_flags, cbz_zero);
            if (eval_valid && decide(eval_kind, cond, m_eval_flags, cbz_zero) && m_cnt < 15)
                m_cnt <= m_cnt + 1;
            if (set_flags) begin
                m_flags <= m_in_flags;
                m_fv    <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && reset_n) begin
            chk("m_flags_q",     32'(flags_q),     32'(m_flags));
            chk("m_flags_valid", 32'(flags_valid), 32'(m_fv));
            chk("m_take_valid",  32'(take_valid),  32'(m_tv));
            chk("m_take",        32'(take),        32'(m_t));
            chk("m_taken_count", 32'(taken_count), 32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic sf, input logic [3:0] fl, input logic ev,
                         input logic [1:0] k, input logic [3:0] c, input logic cbz);
        set_flags     = sf;
        alu_negative  = fl[3];
        alu_zero      = fl[2];
        alu_overflow  = fl[1];
        alu_carry_out = fl[0];
        eval_valid    = ev;
        eval_kind     = k;
        cond          = c;
        cbz_zero      = cbz;
        @(negedge clk);
    endtask

    task automatic async_reset_check(input string tag);
        #2 reset_n = 1'b0;
        #1;
        chk({tag, "_flags_q"},     32'(flags_q),     32'h0);
        chk({tag, "_flags_valid"}, 32'(flags_valid), 32'h0);
        chk({tag, "_take_valid"},  32'(take_valid),  32'h0);
        chk({tag, "_take"},        32'(take),        32'h0);
        chk({tag, "_taken_count"}, 32'(taken_count), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        set_flags = 0; alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
        eval_valid = 0; eval_kind = 2'b00; cond = 4'h0; cbz_zero = 0;
        async_reset_check("rst0");
        started = 1;

        // B.cond on reset flags
        drive(0, 4'h0, 1, 2'b01, 4'h0, 0);
        chk("eq_reset_tv", 32'(take_valid), 32'h1);
        chk("eq_reset_t",  32'(take),       32'h0);
        drive(0, 4'h0, 1, 2'b01, 4'h1, 0);
        chk("ne_reset_t",  32'(take),       32'h1);

        // Flag capture N=1 C=1
        drive(1, 4'b1001, 0, 2'b00, 4'h0, 0);
        chk("cap_flags", 32'(flags_q),     32'h9);
        chk("cap_fv",    32'(flags_valid), 32'h1);
        chk("cap_tv",    32'(take_valid),  32'h0);
        drive(0, 4'h0, 1, 2'b01, 4'hB, 0);
        chk("lt_t", 32'(take), 32'h1);
        drive(0, 4'h0, 1, 2'b01, 4'hA, 0);
        chk("ge_t", 32'(take), 32'h0);
        drive(0, 4'h0, 1, 2'b01, 4'h2, 0);
        chk("hs_t", 32'(take), 32'h1);
        drive(0, 4'h0, 1, 2'b01, 4'h8, 0);
        chk("hi_t", 32'(take), 32'h1);

        // Exhaustive cond x flags sweep, checked by the model each cycle
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                drive(1, 4'(f), 0, 2'b00, 4'h0, 0);
                drive(0, 4'(f ^ 15), 1, 2'b01, 4'(c), 0);
            end
        end

        // CBZ / CBNZ leave flags alone even with other flags on the ALU bus
        drive(1, 4'b0110, 0, 2'b00, 4'h0, 0);
        drive(0, 4'b1001, 1, 2'b10, 4'h0, 1);
        chk("cbz_t",     32'(take),    32'h1);
        chk("cbz_flags", 32'(flags_q), 32'h6);
        drive(0, 4'b1001, 1, 2'b11, 4'h0, 1);
        chk("cbnz_t",     32'(take),    32'h0);
        chk("cbnz_flags", 32'(flags_q), 32'h6);
        drive(0, 4'b1111, 1, 2'b11, 4'h0, 0);
        chk("cbnz0_t", 32'(take), 32'h1);

        // Same-cycle set_flags + B.cond EQ with committed Z=0
        drive(1, 4'b0000, 0, 2'b00, 4'h0, 0);
        drive(1, 4'b0100, 1, 2'b01, 4'h0, 0);
`ifdef FLAG_FWD_EN
        chk("fwd_eq_t", 32'(take), 32'h1);
`else
        chk("fwd_eq_t", 32'(take), 32'h0);
`endif
        chk("fwd_flags", 32'(flags_q), 32'h4);

        // Reset mid-stream drops the pending decision immediately
        drive(0, 4'h0, 1, 2'b00, 4'h0, 0);
        chk("pre_rst_tv", 32'(take_valid), 32'h1);
        async_reset_check("rst1");
        drive(0, 4'h0, 1, 2'b01, 4'h0, 0);
        chk("eq_post_rst_t", 32'(take), 32'h0);

        // Counter saturation: 20 B requests from zero
        async_reset_check("rst2");
        for (int i = 0; i < 20; i++) begin
            drive(0, 4'h0, 1, 2'b00, 4'h0, 0);
            chk("cnt_sat", 32'(taken_count), (i < 15) ? 32'(i + 1) : 32'hF);
        end
        drive(0, 4'h0, 0, 2'b00, 4'h0, 0);
        chk("cnt_hold", 32'(taken_count), 32'hF);
        chk("idle_tv",  32'(take_valid),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
